// File: rtl/periph_timer_pkg.sv
// Shared definitions for periph_timer: register offsets, CTRL/STAT field positions and reset values.
package periph_timer_pkg;

  localparam int REG_OFF_W  = 3;
  localparam int PSEL_W     = 3;
  localparam int PRESCALE_W = 7;

  typedef enum logic [REG_OFF_W-1:0] {
    OFF_CTRL   = 3'd0,
    OFF_STAT   = 3'd1,
    OFF_CNT    = 3'd2,
    OFF_PERIOD = 3'd3,
    OFF_CAP    = 3'd4
  } reg_off_e;

  // CTRL field positions
  localparam int CTRL_EN       = 0;
  localparam int CTRL_IE       = 1;
  localparam int CTRL_AUTO     = 2;
  localparam int CTRL_PSEL_LSB = 3;
  localparam int CTRL_CIE      = 6;

  // STAT field positions
  localparam int STAT_OVF  = 0;
  localparam int STAT_RUN  = 1;
  localparam int STAT_CAPF = 2;

  localparam logic [7:0]            CNT_RESET      = 8'h00;
  localparam logic [7:0]            CAP_RESET      = 8'h00;
  localparam logic [PSEL_W-1:0]     PSEL_RESET     = '0;
  localparam logic [PRESCALE_W-1:0] PRESCALE_RESET = '0;

  // Low-bit mask whose all-ones pattern marks a tick: divide ratio 2^psel.
  function automatic logic [PRESCALE_W-1:0] psel_mask(input logic [PSEL_W-1:0] psel);
    return PRESCALE_W'((8'd1 << psel) - 8'd1);
  endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// Free-running 7-bit prescaler for periph_timer; emits a tick every 2^psel enabled cycles.
module tmr_prescaler
  import periph_timer_pkg::*;
(
  input  logic              clk_ip,
  input  logic              reset_n_ip,
  input  logic              enable,
  input  logic              clear,
  input  logic [PSEL_W-1:0] psel,
  output logic              tick
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] mask;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      count_q <= PRESCALE_RESET;
    end else if (clear) begin
      count_q <= PRESCALE_RESET;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign mask = psel_mask(psel);
  assign tick = enable && ((count_q & mask) == mask);

endmodule

// File: rtl/periph_timer.sv
// 8-bit bus-mapped timer/counter with overflow interrupt.
// Define TMR_CAPTURE_EN to add the cap_ip input-capture channel (CAP register, CAPF flag, CIE enable).
module periph_timer
  import periph_timer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h10,
  parameter logic [7:0] RESET_PERIOD = 8'hFF
) (
  input  logic       clk_ip,
  input  logic       reset_n_ip,
  input  logic [7:0] addr_ip,
  input  logic [7:0] data_ip,
  output logic [7:0] data_op,
  input  logic       wr_en_ip,
  input  logic       rd_en_ip,
`ifdef TMR_CAPTURE_EN
  input  logic       cap_ip,
`endif
  output logic       irq_op
);

`ifdef TMR_CAPTURE_EN
  localparam int WIN_AW = 3;
`else
  localparam int WIN_AW = 2;
`endif

  logic     sel;
  reg_off_e off;
  logic     wr_sel, wr_ctrl, wr_stat, wr_cnt, wr_period;

  assign sel = (addr_ip[7:WIN_AW] == BASE_ADDR[7:WIN_AW]);
  assign off = reg_off_e'(REG_OFF_W'(addr_ip[WIN_AW-1:0]));

  assign wr_sel    = sel & wr_en_ip;
  assign wr_ctrl   = wr_sel && (off == OFF_CTRL);
  assign wr_stat   = wr_sel && (off == OFF_STAT);
  assign wr_cnt    = wr_sel && (off == OFF_CNT);
  assign wr_period = wr_sel && (off == OFF_PERIOD);

  logic              en_q, ie_q, auto_q;
  logic [PSEL_W-1:0] psel_q;
  logic [7:0]        cnt_q, cnt_d, period_q;
  logic              ovf_q, irq_q;
  logic              tick, count_tick;
  logic              ovf_set, oneshot_stop;
  logic              cie_q, capf_q;
  logic [7:0]        cap_q;

  tmr_prescaler u_prescaler (
    .clk_ip     (clk_ip),
    .reset_n_ip (reset_n_ip),
    .enable     (en_q),
    .clear      (wr_ctrl),
    .psel       (psel_q),
    .tick       (tick)
  );

  // A CTRL write that clears EN takes effect on this very edge: the pending tick is dropped.
  assign count_tick = tick & ~(wr_ctrl & ~data_ip[CTRL_EN]);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    cnt_d        = cnt_q;
    ovf_set      = 1'b0;
    oneshot_stop = 1'b0;
    if (wr_cnt) begin
      cnt_d = data_ip;
    end else if (count_tick) begin
      if (cnt_q == period_q) begin
        cnt_d        = CNT_RESET;
        ovf_set      = 1'b1;
        oneshot_stop = ~auto_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      auto_q <= 1'b0;
      psel_q <= PSEL_RESET;
    end else if (wr_ctrl) begin
      en_q   <= data_ip[CTRL_EN];
      ie_q   <= data_ip[CTRL_IE];
      auto_q <= data_ip[CTRL_AUTO];
      psel_q <= data_ip[CTRL_PSEL_LSB +: PSEL_W];
    end else if (oneshot_stop) begin
      en_q <= 1'b0;
    end
  end

  // OVF set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      cnt_q    <= CNT_RESET;
      period_q <= RESET_PERIOD;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wr_period) begin
        period_q <= data_ip;
      end
      ovf_q <= ovf_set | (ovf_q & ~(wr_stat & data_ip[STAT_OVF]));
      irq_q <= (ovf_q & ie_q) | (capf_q & cie_q);
    end
  end

`ifdef TMR_CAPTURE_EN
  logic [2:0] cap_sync_q;
  logic       cap_edge;

  // Stages 0/1 synchronise cap_ip; stage 2 holds the previous synchronised level for edge detect.
  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];

  always_ff @(posedge clk_ip or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      cap_sync_q <= 3'b000;
      cap_q      <= CAP_RESET;
      capf_q     <= 1'b0;
      cie_q      <= 1'b0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], cap_ip};
      if (cap_edge) begin
        cap_q <= cnt_q;
      end
      capf_q <= cap_edge | (capf_q & ~(wr_stat & data_ip[STAT_CAPF]));
      if (wr_ctrl) begin
        cie_q <= data_ip[CTRL_CIE];
      end
    end
  end
`else
  assign cie_q  = 1'b0;
  assign capf_q = 1'b0;
  assign cap_q  = CAP_RESET;
`endif

  logic [7:0] ctrl_rd, stat_rd, rd_data;

  always_comb begin
    ctrl_rd                                 = '0;
    ctrl_rd[CTRL_EN]                        = en_q;
    ctrl_rd[CTRL_IE]                        = ie_q;
    ctrl_rd[CTRL_AUTO]                      = auto_q;
    ctrl_rd[CTRL_PSEL_LSB +: PSEL_W]        = psel_q;
    ctrl_rd[CTRL_CIE]                       = cie_q;
    stat_rd                                 = '0;
    stat_rd[STAT_OVF]                       = ovf_q;
    stat_rd[STAT_RUN]                       = en_q;
    stat_rd[STAT_CAPF]                      = capf_q;
    case (off)
      OFF_CTRL:   rd_data = ctrl_rd;
      OFF_STAT:   rd_data = stat_rd;
      OFF_CNT:    rd_data = cnt_q;
      OFF_PERIOD: rd_data = period_q;
      OFF_CAP:    rd_data = cap_q;
      default:    rd_data = 8'h00;
    endcase
  end

  // Unselected reads return zero so peripheral read buses can be OR-combined.
  assign data_op = (sel & rd_en_ip) ? rd_data : 8'h00;
  assign irq_op  = irq_q;

endmodule

// File: doc/periph_timer.md
Name: periph_timer

Overview:
- 8-bit timer/counter peripheral; the responder end of the CPU peripheral bus (8-bit addr, read/write data, rd_en/wr_en strobes, level IRQ into the CPU's irq_ip).
- Decodes a 4-register window at BASE_ADDR and counts prescaled clock ticks up to a programmable period.
- On reaching the period it sets an overflow flag and raises an interrupt request.
- Read data is returned combinationally so the CPU can consume it within the same cycle.

Parameters:
- BASE_ADDR, 8'h10, first bus address of the register window; must be 4-aligned.
- RESET_PERIOD, 8'hFF, reset value of the PERIOD register.

Ports:
- clk_ip  in  1  system clock; all state updates on the rising edge.
- reset_n_ip  in  1  asynchronous active-low reset.
- addr_ip  in  8  peripheral bus address.
- data_ip  in  8  write data from the CPU.
- data_op  out  8  read data; 8'h00 when not selected, so several peripherals can be OR-combined.
- wr_en_ip  in  1  write strobe.
- rd_en_ip  in  1  read strobe.
- irq_op  out  1  level interrupt request.

Behaviour:
- Select: sel = (addr_ip[7:2] == BASE_ADDR[7:2]).
- Register map (offsets):
  - 0 CTRL: [0] EN, [1] IE, [2] AUTO, [5:3] PSEL, [7:6] read 0.
  - 1 STAT: [0] OVF (write-1-to-clear), [1] RUN (read-only copy of EN), others read 0.
  - 2 CNT: read/write.
  - 3 PERIOD: read/write.
- Reset values: CTRL=0, STAT=0, CNT=0, PERIOD=RESET_PERIOD, prescaler=0, irq_op=0, data_op=0.
- Read path: data_op = (sel & rd_en_ip) ? reg[addr_ip[1:0]] : 8'h00, purely combinational, zero latency. Reads have no side effects.
- Writes: sampled on rising clk_ip when sel & wr_en_ip. Reserved bits are ignored.
- Prescaler: 7-bit free counter, runs only while EN=1. tick=1 when prescaler[PSEL-1:0] is all ones, giving a divide ratio of 2^PSEL; PSEL=0 ticks every cycle. Any write to CTRL clears the prescaler.
- Counter on tick:
  - CNT==PERIOD: CNT<=0 and OVF<=1. If AUTO=0 (one-shot), EN<=0 in the same edge.
  - Otherwise: CNT<=CNT+1 (8-bit).
- PERIOD=0 sets OVF on every tick, with CNT held at 0.
- Writing CNT to a value above PERIOD: CNT counts up, wraps 8'hFF->0, then matches normally.
- irq_op = OVF & IE, registered output, asserted the cycle after OVF sets.
- Simultaneous events:
  - CPU write to CNT and tick in the same cycle: the write wins; the prescaler is not disturbed.
  - OVF set and write-1-to-clear in the same cycle: the set wins, OVF stays 1.
  - Writing EN=0 stops counting immediately; CNT is retained.
  - CTRL write on a one-shot expiry edge: the CTRL write value wins for EN.
- Unused offsets: none exist in the base map. Addresses outside the window are ignored.
- Reset asserted mid-count: all state returns to reset values asynchronously. Counting resumes only after software sets EN.

Optional Feature:
- Macro: TMR_CAPTURE_EN.
- Defined:
  - Adds port cap_ip (in, 1), synchronised by two flops.
  - A rising edge after synchronisation latches CNT into CAP at offset 4, widening the window to 8 addresses with BASE_ADDR[7:3] decode, and sets STAT[2] CAPF (write-1-to-clear).
  - CTRL[6] CIE is added; irq_op = (OVF&IE) | (CAPF&CIE).
  - Capture in the same cycle as a CNT write latches the pre-write CNT.
- Undefined:
  - No cap_ip port; STAT[2] and CTRL[6] read 0; 4-address window only.

Decomposition:
- Package periph_timer_pkg: register offset constants, CTRL/STAT bit-position constants, reset-value constants.
- One sub-module, tmr_prescaler: enable, clear and PSEL in; tick out.

Test Plan:
- Reset: assert reset_n_ip=0 mid-run -> all registers readable as 0 (PERIOD=8'hFF), irq_op=0 immediately.
- Auto-reload: PERIOD=3, CTRL=8'h07 (EN, IE, AUTO, PSEL=0) -> CNT sequence 0,1,2,3,0; OVF set on the wrap edge, irq_op high the next cycle; write STAT=8'h01 -> irq_op low.
- Prescale and one-shot: PERIOD=2, CTRL=8'h19 (EN, PSEL=3, AUTO=0) -> CNT increments every 8 cycles; after the match CNT=0, EN=0, STAT reads 8'h01.
- Collisions: force CNT write on a tick cycle -> written value is held; W1C on the OVF-set cycle -> OVF remains 1.
- Decode: read/write at BASE_ADDR+4 and BASE_ADDR-1 (capture off) -> data_op=8'h00, no state change; rd_en_ip=0 on a valid address -> data_op=8'h00.
- TMR_CAPTURE_EN: pulse cap_ip while CNT=8'h2A -> CAP=8'h2A, CAPF=1, irq_op=1 with CIE=1.
